// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared states, ALU/cmd codes and condition codes for the multicycle controller
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
               (cmd == CMD_CMP) || (cmd == CMD_ORR);
    endfunction

    function automatic logic [1:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - shared memory port between controller and memory
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_ready;
    logic adr_src;
    logic mem_write;

    modport master (output mem_req, output adr_src, output mem_write, input mem_ready);
    modport slave  (input mem_req, input adr_src, input mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_cond_check.sv
// rtl/multicycle_ctrl_cond_check.sv - ARM condition code evaluation against NZCV
module cond_check
    import multicycle_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ok
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = z;
            COND_NE: cond_ok = !z;
            COND_CS: cond_ok = c;
            COND_CC: cond_ok = !c;
            COND_MI: cond_ok = n;
            COND_PL: cond_ok = !n;
            COND_VS: cond_ok = v;
            COND_VC: cond_ok = !v;
            COND_HI: cond_ok = c && !z;
            COND_LS: cond_ok = !c || z;
            COND_GE: cond_ok = (n == v);
            COND_LT: cond_ok = (n != v);
            COND_GT: cond_ok = !z && (n == v);
            COND_LE: cond_ok = z || (n != v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle ARM control FSM with NZCV flags register
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int         ALU_W      = 2,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cond,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic [3:0]       rd,
    input  logic [3:0]       alu_flags,
    multicycle_ctrl_if.master mem,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [ALU_W-1:0] alu_control,
    output logic [1:0]       imm_src,
    output logic [1:0]       reg_src,
    output logic             branch_link,
    output logic [3:0]       flags,
    output logic             undef_instr
);
    state_t     state, state_n;
    logic [3:0] flags_n;
    logic [3:0] cmd;
    logic       is_cmp, cond_ok;
    logic       mem_req_d, mem_write_d, ir_write_d, pc_write_d, reg_write_d;
    logic       branch_link_d, undef_d;
    logic [1:0] alu_code;

    assign cmd    = funct[4:1];
    assign is_cmp = (cmd == CMD_CMP);

    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags),
        .cond_ok (cond_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            flags <= FLAG_RESET;
        end else begin
            state <= state_n;
            flags <= flags_n;
        end
    end

    always_comb begin
        state_n       = state;
        flags_n       = flags;
        mem_req_d     = 1'b0;
        mem_write_d   = 1'b0;
        ir_write_d    = 1'b0;
        pc_write_d    = 1'b0;
        reg_write_d   = 1'b0;
        branch_link_d = 1'b0;
        undef_d       = 1'b0;
        mem.adr_src   = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_code      = ALU_ADD;
        reg_src       = 2'b00;
        case (state)
            FETCH: begin
                mem_req_d  = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem.mem_ready) begin
                    ir_write_d = 1'b1;
                    pc_write_d = 1'b1;
                    state_n    = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                if (!cond_ok) begin
                    state_n = FETCH;
                end else begin
                    case (op)
                        2'b01: state_n = MEMADR;
                        2'b10: state_n = BRANCH;
                        2'b00: begin
                            if (!cmd_supported(cmd)) begin
                                undef_d = 1'b1;
                                state_n = FETCH;
                            end else begin
                                state_n = funct[5] ? EXECUTEI : EXECUTER;
                            end
                        end
                        default: begin
                            undef_d = 1'b1;
                            state_n = FETCH;
                        end
                    endcase
                end
            end
            MEMADR: begin
                alu_src_b = 2'b01;
                state_n   = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_d   = 1'b1;
                mem.adr_src = 1'b1;
                if (mem.mem_ready) state_n = MEMWB;
            end
            MEMWB: begin
                result_src  = 2'b01;
                reg_write_d = 1'b1;
                pc_write_d  = (rd == 4'd15);
                state_n     = FETCH;
            end
            MEMWRITE: begin
                mem_req_d   = 1'b1;
                mem.adr_src = 1'b1;
                mem_write_d = 1'b1;
                reg_src     = 2'b10;
                if (mem.mem_ready) state_n = FETCH;
            end
            EXECUTER, EXECUTEI: begin
                alu_src_b = (state == EXECUTEI) ? 2'b01 : 2'b00;
                alu_code  = cmd_alu(cmd);
                // Logical ops carry no meaningful C/V out of the ALU, so those bits hold.
                if (funct[0] || is_cmp) begin
                    if (cmd == CMD_AND || cmd == CMD_ORR)
                        flags_n = {alu_flags[3:2], flags[1:0]};
                    else
                        flags_n = alu_flags;
                end
                state_n = ALUWB;
            end
            ALUWB: begin
                reg_write_d = !is_cmp;
                pc_write_d  = (rd == 4'd15) && !is_cmp;
                state_n     = FETCH;
            end
            BRANCH: begin
                reg_src       = 2'b01;
                alu_src_b     = 2'b01;
                result_src    = 2'b10;
                pc_write_d    = 1'b1;
                branch_link_d = funct[4];
                state_n       = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    // Enables are forced low during reset so an abandoned access cannot write anything.
    assign mem.mem_req   = mem_req_d     & ~reset;
    assign mem.mem_write = mem_write_d   & ~reset;
    assign ir_write      = ir_write_d    & ~reset;
    assign pc_write      = pc_write_d    & ~reset;
    assign reg_write     = reg_write_d   & ~reset;
    assign branch_link   = branch_link_d & ~reset;
    assign undef_instr   = undef_d       & ~reset;
    assign alu_control   = ALU_W'(alu_code);
    assign imm_src       = op;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for the multicycle controller
module tb_multicycle_ctrl;
    localparam logic [3:0] FLAG_RESET = 4'b0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cond = 4'd0, rd = 4'd0, alu_flags = 4'd0;
    logic [1:0] op = 2'd0;
    logic [5:0] funct = 6'd0;
    logic       ir_write, pc_write, reg_write, branch_link, undef_instr;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_control, imm_src, reg_src;
    logic [3:0] flags;

    multicycle_ctrl_if mem ();

    multicycle_ctrl #(.ALU_W(2), .FLAG_RESET(FLAG_RESET)) dut (
        .clk         (clk),
        .reset       (reset),
        .cond        (cond),
        .op          (op),
        .funct       (funct),
        .rd          (rd),
        .alu_flags   (alu_flags),
        .mem         (mem.master),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .reg_src     (reg_src),
        .branch_link (branch_link),
        .flags       (flags),
        .undef_instr (undef_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rst;
        logic [17:0] vec;
        logic [3:0]  flg;
        string       tag;
    } rec_t;

    rec_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_flags = FLAG_RESET;
    logic [3:0] n_cond = 4'd0, n_rd = 4'd0, n_alu = 4'd0;
    logic [1:0] n_op = 2'd0;
    logic [5:0] n_funct = 6'd0;

    // {mem_req, adr_src, ir_write, pc_write, reg_write, mem_write, branch_link, undef_instr,
    //  alu_src_a, alu_src_b, result_src, alu_control, reg_src}
    function automatic logic [17:0] mk(input logic mreq, asrc, irw, pcw, rgw, mw, bl, und,
                                       input logic [1:0] a, b, res, alu, rsrc);
        return {mreq, asrc, irw, pcw, rgw, mw, bl, und, a, b, res, alu, rsrc};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic rdy, input logic rst, input logic [17:0] v);
        rec_t r;
        r.tag = tag;
        r.rdy = rdy;
        r.rst = rst;
        r.vec = v;
        r.flg = exp_flags;
        sb.push_back(r);
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af);
        n_cond = c; n_op = o; n_funct = f; n_rd = r; n_alu = af;
    endtask

    task automatic push_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            push("fetch_wait", 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0, 2'b01,2'b10,2'b10,2'b00,2'b00));
        push("fetch", 1'b1, 1'b0, mk(1,0,1,1,0,0,0,0, 2'b01,2'b10,2'b10,2'b00,2'b00));
    endtask

    task automatic push_decode(input logic und);
        push("decode", 1'b1, 1'b0, mk(0,0,0,0,0,0,0,und, 2'b01,2'b10,2'b00,2'b00,2'b00));
    endtask

    // Pops one record per cycle; instruction fields change only at the first cycle of a new
    // instruction so the previous instruction's final transition sees its own encoding.
    task automatic drain;
        rec_t        r;
        logic        first;
        logic [17:0] got;
        first = 1'b1;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge clk);
            if (first) begin
                cond = n_cond; op = n_op; funct = n_funct; rd = n_rd; alu_flags = n_alu;
                first = 1'b0;
            end
            mem.mem_ready = r.rdy;
            reset = r.rst;
            #1;
            got = {mem.mem_req, mem.adr_src, ir_write, pc_write, reg_write, mem.mem_write,
                   branch_link, undef_instr, alu_src_a, alu_src_b, result_src, alu_control, reg_src};
            check(r.tag, 32'(got), 32'(r.vec));
            check({r.tag, "_flags"}, 32'(flags), 32'(r.flg));
            check({r.tag, "_imm_src"}, 32'(imm_src), 32'(n_op));
        end
    endtask

    task automatic do_dp(input logic [3:0] c, input logic [5:0] f, input logic [3:0] r,
                         input logic [3:0] af);
        logic [3:0] cmd;
        logic [1:0] alu;
        logic       is_cmp;
        cmd    = f[4:1];
        is_cmp = (cmd == 4'b1010);
        case (cmd)
            4'b0010, 4'b1010: alu = 2'b01;
            4'b0000:          alu = 2'b10;
            4'b1100:          alu = 2'b11;
            default:          alu = 2'b00;
        endcase
        set_instr(c, 2'b00, f, r, af);
        push_fetch(0);
        push_decode(1'b0);
        push("exec", 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0, 2'b00, f[5] ? 2'b01 : 2'b00, 2'b00, alu, 2'b00));
        if (f[0] || is_cmp)
            exp_flags = (cmd == 4'b0000 || cmd == 4'b1100) ? {af[3:2], exp_flags[1:0]} : af;
        push("aluwb", 1'b1, 1'b0, mk(0,0,0, !is_cmp && (r == 4'd15), !is_cmp, 0,0,0,
                                    2'b00,2'b00,2'b00,2'b00,2'b00));
        drain();
    endtask

    task automatic do_ldr(input logic [3:0] r, input int waits);
        set_instr(4'b1110, 2'b01, 6'b011001, r, 4'b1111);
        push_fetch(0);
        push_decode(1'b0);
        push("memadr", 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,2'b00));
        for (int i = 0; i < waits; i++)
            push("memread_wait", 1'b0, 1'b0, mk(1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00));
        push("memread", 1'b1, 1'b0, mk(1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00));
        push("memwb", 1'b1, 1'b0, mk(0,0,0, r == 4'd15, 1,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00));
        drain();
    endtask

    task automatic do_str(input int fwaits, input int mwaits, input logic do_reset);
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd4, 4'b1111);
        push_fetch(fwaits);
        push_decode(1'b0);
        push("memadr", 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,2'b00));
        for (int i = 0; i < mwaits; i++)
            push("memwrite_wait", 1'b0, 1'b0, mk(1,1,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b10));
        if (do_reset) begin
            push("memwrite_rst", 1'b0, 1'b1, mk(0,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b10));
            exp_flags = FLAG_RESET;
        end else begin
            push("memwrite", 1'b1, 1'b0, mk(1,1,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b10));
        end
        drain();
    endtask

    task automatic do_branch(input logic [3:0] c, input logic link, input logic taken);
        set_instr(c, 2'b10, {1'b0, link, 4'b0000}, 4'd0, 4'b1111);
        push_fetch(0);
        push_decode(1'b0);
        if (taken)
            push("branch", 1'b1, 1'b0, mk(0,0,0,1,0,0,link,0, 2'b00,2'b01,2'b10,2'b00,2'b01));
        drain();
    endtask

    task automatic do_short(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic und);
        set_instr(c, o, f, 4'd15, 4'b1111);
        push_fetch(0);
        push_decode(und);
        drain();
    endtask

    initial begin
        mem.mem_ready = 1'b0;
        repeat (2) push("reset", 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0, 2'b01,2'b10,2'b10,2'b00,2'b00));
        drain();

        do_dp(4'b1110, 6'b001001, 4'd1, 4'b0100);     // ADDS R1: flags -> 0100
        do_branch(4'b0000, 1'b1, 1'b1);               // BLEQ with Z=1
        do_dp(4'b1110, 6'b010101, 4'd15, 4'b1000);    // CMP, rd=15 must not write PC
        do_branch(4'b0000, 1'b0, 1'b0);               // BEQ with Z=0
        do_ldr(4'd3, 3);
        do_ldr(4'd15, 0);
        do_str(2, 0, 1'b0);
        do_dp(4'b1110, 6'b100001, 4'd15, 4'b0111);    // ANDS imm: only N,Z update -> 0100
        do_dp(4'b1110, 6'b011000, 4'd2, 4'b1011);     // ORR without S: flags hold
        do_short(4'b1111, 2'b00, 6'b001001, 1'b0);    // cond 1111 never executes
        do_short(4'b1110, 2'b11, 6'b000000, 1'b1);    // op=11 undefined
        do_short(4'b1110, 2'b00, 6'b000010, 1'b1);    // unsupported cmd
        do_short(4'b0001, 2'b11, 6'b000000, 1'b0);    // NE fails with Z=1: no undef pulse
        do_str(0, 2, 1'b1);                           // reset during MEMWRITE wait
        do_dp(4'b1110, 6'b001000, 4'd2, 4'b1111);     // ADD without S after reset

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
